instr_sequencer: RTL

//  Multi-cycle fetch/decode/execute sequencer for the Simple Computer.
//  - Fetches each instruction through a req/ack memory handshake and holds it in IR.
//  - Decodes the opcode class and drives the PC-update controls: pc_en, PL, JB, BC.
//  - Sequences register-file and data-memory strobes.
//  - Branch-condition evaluation stays in the PC controller; this block only requests the branch.

---
 rtl/sc_pkg.sv | 65 ++++++
 rtl/instr_sequencer_timeout.sv | 44 ++++
 rtl/instr_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the Simple Computer instruction sequencer.
// Latency: none; types, constants and pure decode helpers only.
// Backpressure: none.
package sc_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } seq_state_e;

  // Instruction register layout
  localparam int IR_W      = 16;
  localparam int IR_OPC_HI = 15;
  localparam int IR_OPC_LO = 13;

  // Opcode classes carried in ir[15:13]
  localparam logic [2:0] OPC_ALU    = 3'b000;
  localparam logic [2:0] OPC_LOAD   = 3'b001;
  localparam logic [2:0] OPC_STORE  = 3'b010;
  localparam logic [2:0] OPC_HALT   = 3'b011;
  localparam logic [2:0] OPC_NOP0   = 3'b100;
  localparam logic [2:0] OPC_NOP1   = 3'b101;
  localparam logic [2:0] OPC_BRANCH = 3'b110;
  localparam logic [2:0] OPC_JUMP   = 3'b111;

  // Strobes driven during the EXEC cycle (pc_en is implied for every class)
  typedef struct packed {
    logic rf_we;
    logic pl;
    logic jb;
    logic bc;
  } exec_ctl_t;

  // Map an opcode class onto its EXEC-cycle strobes.
  // NOP classes fall through to all-zero: they retire like ALU ops but never write.
  function automatic exec_ctl_t exec_ctl(input logic [2:0] opc);
    exec_ctl_t c;
    c = '0;
    case (opc)
      OPC_ALU, OPC_LOAD: c.rf_we = 1'b1;
      OPC_BRANCH: begin
        c.pl = 1'b1;
        c.bc = 1'b1;
      end
      OPC_JUMP: begin
        c.pl = 1'b1;
        c.jb = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Classes that need a data-memory access between DECODE and EXEC
  function automatic logic is_mem_opc(input logic [2:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/instr_sequencer_timeout.sv
// Memory-request wait counter: counts un-acked request cycles and flags expiry.
// Latency: expired_o is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; the sequencer owns clear/enable, TIMEOUT=0 never expires.
module seq_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Count value at which one more un-acked cycle reaches TIMEOUT
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam bit ENABLED = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear between requests, step on every waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait-count register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry only on a waiting cycle, so an ack arriving on the limit cycle wins
  assign expired_o = ENABLED && en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: drives memory req/ack, PC controls and RF strobes.
// Latency: ALU/BRANCH/JUMP 3 cycles, LOAD/STORE 4, plus one per memory wait cycle.
// Backpressure: mem_req held until mem_ack; a request un-acked for TIMEOUT cycles faults.
module instr_sequencer
  import sc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic [15:0]      ir,
  output logic             rf_we,
  output logic             pc_en,
  output logic             PL,
  output logic             JB,
  output logic             BC,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_e       state_q;
  logic [IR_W-1:0]  ir_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             addr_sel_q;
  logic             rf_we_q;
  logic             pc_en_q;
  logic             pl_q;
  logic             jb_q;
  logic             bc_q;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] count_q;

  logic [2:0]       opc;
  exec_ctl_t        ctl;
  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_expired;

  // Decode always works from the held instruction
  assign opc = ir_q[IR_OPC_HI:IR_OPC_LO];
  assign ctl = exec_ctl(opc);

  // Wait counter restarts whenever no request is outstanding
  assign tmo_clr = !mem_req_q;
  assign tmo_en  = mem_req_q && !mem_ack;

  seq_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_en_q    <= 1'b0;
      pl_q       <= 1'b0;
      jb_q       <= 1'b0;
      bc_q       <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      // EXEC strobes are single-cycle; re-armed only on entry to EXEC
      rf_we_q <= 1'b0;
      pc_en_q <= 1'b0;
      pl_q    <= 1'b0;
      jb_q    <= 1'b0;
      bc_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            ir_q      <= mem_rdata;
            state_q   <= S_DECODE;
            mem_req_q <= 1'b0;
          end else if (tmo_expired) begin
            state_q   <= S_FAULT;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end
        end

        S_DECODE: begin
          if (is_mem_opc(opc)) begin
            state_q    <= S_MEM;
            mem_req_q  <= 1'b1;
            addr_sel_q <= 1'b1;
            mem_we_q   <= (opc == OPC_STORE);
          end else if (opc == OPC_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            pc_en_q <= 1'b1;
            rf_we_q <= ctl.rf_we;
            pl_q    <= ctl.pl;
            jb_q    <= ctl.jb;
            bc_q    <= ctl.bc;
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            state_q    <= S_EXEC;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            pc_en_q    <= 1'b1;
            rf_we_q    <= ctl.rf_we;
            pl_q       <= ctl.pl;
            jb_q       <= ctl.jb;
            bc_q       <= ctl.bc;
          end else if (tmo_expired) begin
            state_q    <= S_FAULT;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            fault_q    <= 1'b1;
          end
        end

        S_EXEC: begin
          // Retire here; the counter wraps silently
          count_q <= count_q + CNT_W'(1);
          if (run) begin
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end

        // Terminal states: only reset leaves them
        S_HALT:  state_q <= S_HALT;
        S_FAULT: state_q <= S_FAULT;

        default: begin
          state_q    <= S_IDLE;
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
          addr_sel_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign addr_sel    = addr_sel_q;
  assign ir          = ir_q;
  assign rf_we       = rf_we_q;
  assign pc_en       = pc_en_q;
  assign PL          = pl_q;
  assign JB          = jb_q;
  assign BC          = bc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule
